// File: rtl/ppi_cmd_strobe.sv
// ppi_cmd_strobe: decodes 6-byte command frames from the PPI receiver and
// schedules one timed strobe pulse on TNO/TNC/TOBM/TNI/TKI.
// Delay and width are counted in ticks of the 1 us timebase.
// Optional macro PPI_CMD_STAT_EN adds saturating frame statistics counters.
//
// Receiver FSM
//   state      | meaning
//   RX_HUNT    | waiting for SYNC_BYTE
//   RX_COLLECT | storing B1..B5, inter-byte gap timer running
// Scheduler FSM
//   state      | meaning
//   SCH_IDLE   | no strobe scheduled
//   SCH_WAIT   | counting down the delay
//   SCH_PULSE  | strobe[ch] high, counting down the width
module ppi_cmd_strobe #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [15:0] TIMEOUT_US = 16'd100,
    parameter int          NCH        = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           t1us,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic [NCH-1:0] strobe,
    output logic           busy,
    output logic           frame_ok,
    output logic           frame_err,
    output logic           busy_err,
    output logic           fail
`ifdef PPI_CMD_STAT_EN
    ,
    output logic [15:0]    ok_cnt,
    output logic [15:0]    err_cnt,
    output logic [15:0]    drop_cnt
`endif
);

    typedef enum logic {RX_HUNT, RX_COLLECT} rx_state_t;
    typedef enum logic [1:0] {SCH_IDLE, SCH_WAIT, SCH_PULSE} sch_state_t;

    rx_state_t      rx_state, rx_next;
    logic [2:0]     idx, idx_next;
    logic [15:0]    gap_cnt, gap_next;
    logic [7:0]     cmd_q, dly_hi_q, dly_lo_q, wid_q;
    logic           frame_done, timeout;

    logic           csum_ok, is_abort, chan_bad;
    logic           do_abort, do_load, do_drop, do_err;

    sch_state_t     sch_state, sch_next;
    logic [15:0]    cnt, cnt_next;
    logic [2:0]     ch_q, ch_next;
    logic [7:0]     wid_s, wid_s_next;
    logic [NCH-1:0] strobe_next;

    // Receiver next-state: sync hunt, byte index and inter-byte gap timeout.
    always_comb begin
        rx_next    = rx_state;
        idx_next   = idx;
        gap_next   = gap_cnt;
        frame_done = 1'b0;
        timeout    = 1'b0;
        case (rx_state)
            RX_HUNT: begin
                gap_next = '0;
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    rx_next  = RX_COLLECT;
                    idx_next = 3'd1;
                end
            end
            RX_COLLECT: begin
                if (rx_valid) begin
                    // A byte clears the gap timer even if a tick lands in the same clk.
                    gap_next = '0;
                    idx_next = idx + 3'd1;
                    if (idx == 3'd5) begin
                        frame_done = 1'b1;
                        rx_next    = RX_HUNT;
                        idx_next   = '0;
                    end
                end else if (t1us) begin
                    if (gap_cnt >= (TIMEOUT_US - 16'd1)) begin
                        timeout  = 1'b1;
                        rx_next  = RX_HUNT;
                        idx_next = '0;
                        gap_next = '0;
                    end else begin
                        gap_next = gap_cnt + 16'd1;
                    end
                end
            end
            default: begin
                rx_next  = RX_HUNT;
                idx_next = '0;
                gap_next = '0;
            end
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_HUNT;
            idx      <= '0;
            gap_cnt  <= '0;
        end else begin
            rx_state <= rx_next;
            idx      <= idx_next;
            gap_cnt  <= gap_next;
        end
    end

    // Capture frame bytes B1..B4; B5 is compared straight from rx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= '0;
            dly_hi_q <= '0;
            dly_lo_q <= '0;
            wid_q    <= '0;
        end else if (rx_valid && (rx_state == RX_COLLECT)) begin
            case (idx)
                3'd1:    cmd_q    <= rx_data;
                3'd2:    dly_hi_q <= rx_data;
                3'd3:    dly_lo_q <= rx_data;
                3'd4:    wid_q    <= rx_data;
                default: ;
            endcase
        end
    end

    assign csum_ok  = ((cmd_q ^ dly_hi_q ^ dly_lo_q ^ wid_q) == rx_data);
    assign is_abort = cmd_q[7];
    assign chan_bad = (cmd_q[2:0] >= 3'(NCH));

    assign do_err   = frame_done && (!csum_ok || (!is_abort && chan_bad));
    assign do_abort = frame_done && csum_ok && is_abort;
    assign do_load  = frame_done && csum_ok && !is_abort && !chan_bad && (sch_state == SCH_IDLE);
    assign do_drop  = frame_done && csum_ok && !is_abort && !chan_bad && (sch_state != SCH_IDLE);

    // Scheduler next-state: delay countdown, pulse countdown, abort override.
    always_comb begin
        sch_next   = sch_state;
        cnt_next   = cnt;
        ch_next    = ch_q;
        wid_s_next = wid_s;
        case (sch_state)
            SCH_IDLE: begin
                if (do_load) begin
                    sch_next   = SCH_WAIT;
                    cnt_next   = {dly_hi_q, dly_lo_q};
                    ch_next    = cmd_q[2:0];
                    wid_s_next = wid_q;
                end
            end
            SCH_WAIT: begin
                if (t1us) begin
                    if (cnt == 16'd0) begin
                        if (wid_s == 8'd0) begin
                            sch_next = SCH_IDLE;
                        end else begin
                            sch_next = SCH_PULSE;
                            cnt_next = {8'h00, wid_s};
                        end
                    end else begin
                        cnt_next = cnt - 16'd1;
                    end
                end
            end
            SCH_PULSE: begin
                if (t1us) begin
                    if (cnt <= 16'd1) begin
                        sch_next = SCH_IDLE;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt - 16'd1;
                    end
                end
            end
            default: begin
                sch_next = SCH_IDLE;
                cnt_next = '0;
            end
        endcase
        // Abort beats any tick processed in the same clk.
        if (do_abort) begin
            sch_next = SCH_IDLE;
            cnt_next = '0;
        end
        strobe_next = '0;
        for (int i = 0; i < NCH; i++) begin
            strobe_next[i] = (sch_next == SCH_PULSE) && (ch_next == 3'(i));
        end
    end

    // Scheduler state register; strobe is registered so it is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sch_state <= SCH_IDLE;
            cnt       <= '0;
            ch_q      <= '0;
            wid_s     <= '0;
            strobe    <= '0;
        end else begin
            sch_state <= sch_next;
            cnt       <= cnt_next;
            ch_q      <= ch_next;
            wid_s     <= wid_s_next;
            strobe    <= strobe_next;
        end
    end

    assign busy = (sch_state != SCH_IDLE);

    // Status pulses and the sticky fail flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            busy_err  <= 1'b0;
            fail      <= 1'b0;
        end else begin
            frame_ok  <= do_abort || do_load;
            frame_err <= do_err || timeout;
            busy_err  <= do_drop;
            if (do_abort || do_load) begin
                fail <= 1'b0;
            end else if (do_err || timeout) begin
                fail <= 1'b1;
            end
        end
    end

`ifdef PPI_CMD_STAT_EN
    // Saturating frame statistics, stepped on the same edge as the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt   <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if ((do_abort || do_load) && (ok_cnt != 16'hFFFF)) begin
                ok_cnt <= ok_cnt + 16'd1;
            end
            if ((do_err || timeout) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (do_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ppi_cmd_strobe.sv
// Testbench for ppi_cmd_strobe: directed frames from the test plan followed by
// randomized frames, all checked every clk against a tick-counting model.
module tb_ppi_cmd_strobe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       t1us = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [4:0] strobe;
    logic       busy, frame_ok, frame_err, busy_err, fail;
`ifdef PPI_CMD_STAT_EN
    logic [15:0] ok_cnt, err_cnt, drop_cnt;
    int          m_okc = 0, m_errc = 0, m_dropc = 0;
`endif

    int  checks = 0;
    int  errors = 0;
    int  phase = 0;
    bit  tick_en = 1'b1;

    // Reference model state: a scheduled pulse is described by when it was
    // loaded (tick count since load) plus its delay, width and channel.
    bit         m_active = 1'b0;
    bit         m_fail = 1'b0;
    int         m_delay = 0, m_width = 0, m_ticks = 0, m_ch = 0, m_gap = 0;
    logic [7:0] frm[$];
    bit         exp_ok = 1'b0, exp_err = 1'b0, exp_berr = 1'b0;
    int         hi_cycles = 0, err_pulses = 0;

    ppi_cmd_strobe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .t1us      (t1us),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .strobe    (strobe),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .busy_err  (busy_err),
        .fail      (fail)
`ifdef PPI_CMD_STAT_EN
        ,
        .ok_cnt    (ok_cnt),
        .err_cnt   (err_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_strobe();
        logic [4:0] es;
        es = '0;
        if (m_active && (m_ticks >= m_delay + 1) && (m_ticks <= m_delay + m_width))
            es[m_ch] = 1'b1;
        return es;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_fail   = 1'b0;
        m_gap    = 0;
        frm.delete();
        exp_ok   = 1'b0;
        exp_err  = 1'b0;
        exp_berr = 1'b0;
`ifdef PPI_CMD_STAT_EN
        m_okc = 0; m_errc = 0; m_dropc = 0;
`endif
    endtask

    task automatic eval_frame(input bit busy_before);
        logic [7:0] c;
        bit ok;
        c  = frm[1];
        ok = ((frm[1] ^ frm[2] ^ frm[3] ^ frm[4]) == frm[5]);
        if (!ok || (!c[7] && (c[2:0] > 3'd4))) begin
            exp_err = 1'b1;
            m_fail  = 1'b1;
        end else if (c[7]) begin
            m_active = 1'b0;
            exp_ok   = 1'b1;
            m_fail   = 1'b0;
        end else if (!busy_before) begin
            m_active = 1'b1;
            m_ticks  = 0;
            m_delay  = int'({frm[2], frm[3]});
            m_width  = int'(frm[4]);
            m_ch     = int'(c[2:0]);
            exp_ok   = 1'b1;
            m_fail   = 1'b0;
        end else begin
            exp_berr = 1'b1;
        end
    endtask

    // Apply one clock edge's worth of events to the model.
    task automatic model_edge();
        bit busy_before;
        exp_ok = 1'b0; exp_err = 1'b0; exp_berr = 1'b0;
        busy_before = m_active;
        if (t1us && m_active) begin
            m_ticks++;
            if (m_ticks > m_delay + m_width) m_active = 1'b0;
        end
        if (frm.size() == 0) begin
            if (rx_valid && (rx_data == 8'hA5)) begin
                frm.push_back(rx_data);
                m_gap = 0;
            end
        end else if (rx_valid) begin
            frm.push_back(rx_data);
            m_gap = 0;
            if (frm.size() == 6) begin
                eval_frame(busy_before);
                frm.delete();
            end
        end else if (t1us) begin
            m_gap++;
            if (m_gap >= 100) begin
                exp_err = 1'b1;
                m_fail  = 1'b1;
                m_gap   = 0;
                frm.delete();
            end
        end
`ifdef PPI_CMD_STAT_EN
        if (exp_ok   && m_okc   < 65535) m_okc++;
        if (exp_err  && m_errc  < 65535) m_errc++;
        if (exp_berr && m_dropc < 65535) m_dropc++;
`endif
    endtask

    task automatic cyc();
        t1us = tick_en && (phase == 19);
        @(posedge clk);
        phase = (phase == 19) ? 0 : phase + 1;
        model_edge();
        #1;
        chk("strobe", 32'(strobe), 32'(exp_strobe()));
        chk("busy", 32'(busy), 32'(m_active));
        chk("frame_ok", 32'(frame_ok), 32'(exp_ok));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        chk("busy_err", 32'(busy_err), 32'(exp_berr));
        chk("fail", 32'(fail), 32'(m_fail));
`ifdef PPI_CMD_STAT_EN
        chk("ok_cnt", 32'(ok_cnt), 32'(m_okc));
        chk("err_cnt", 32'(err_cnt), 32'(m_errc));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_dropc));
`endif
        if (strobe != 5'd0) hi_cycles++;
        if (frame_err) err_pulses++;
        rx_valid = 1'b0;
        t1us     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        cyc();
    endtask

    task automatic send6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        send_byte(b0); send_byte(b1); send_byte(b2);
        send_byte(b3); send_byte(b4); send_byte(b5);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while (m_active && (i < limit)) begin
            cyc();
            i++;
        end
        cyc();
        chk("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_strobe(input int limit);
        int i;
        i = 0;
        while ((exp_strobe() == 5'd0) && (i < limit)) begin
            cyc();
            i++;
        end
        chk("wait_strobe_seen", 32'(strobe != 5'd0), 32'd1);
    endtask

    initial begin
        int h0, e0;
        logic [7:0] c, hi, lo, w, cs, nz;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobe", 32'(strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({frame_ok, frame_err, busy_err, fail}), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Good frame: ch2, delay 3, width 4 -> 80 clk of strobe[2].
        h0 = hi_cycles;
        send6(8'hA5, 8'h02, 8'h00, 8'h03, 8'h04, 8'h05);
        chk("a_frame_ok", 32'(frame_ok), 32'd1);
        chk("a_busy", 32'(busy), 32'd1);
        wait_idle(400);
        chk("a_high_clks", 32'(hi_cycles - h0), 32'd80);

        // Bad checksum.
        h0 = hi_cycles;
        send6(8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'hFF);
        chk("bad_frame_err", 32'(frame_err), 32'd1);
        idle(100);
        chk("bad_fail", 32'(fail), 32'd1);
        chk("bad_no_strobe", 32'(hi_cycles - h0), 32'd0);

        // Recovery: ch0, delay 0, width 1.
        h0 = hi_cycles;
        send6(8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
        chk("rec_fail_clr", 32'(fail), 32'd0);
        wait_idle(200);
        chk("rec_high_clks", 32'(hi_cycles - h0), 32'd20);

        // Second frame during WAIT of delay 0x0100 is dropped.
        h0 = hi_cycles;
        send6(8'hA5, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02);
        idle(600);
        send6(8'hA5, 8'h03, 8'h00, 8'h01, 8'h01, 8'h03);
        chk("drop_busy_err", 32'(busy_err), 32'd1);
        wait_idle(8000);
        chk("drop_high_clks", 32'(hi_cycles - h0), 32'd40);

        // Abort while strobe[3] is high.
        send6(8'hA5, 8'h03, 8'h00, 8'h01, 8'h0A, 8'h08);
        wait_strobe(200);
        idle(7);
        send6(8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80);
        chk("abort_ok", 32'(frame_ok), 32'd1);
        chk("abort_strobe", 32'(strobe), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        idle(30);

        // SYNC value as cmd byte is data: abort to a bad channel, still accepted.
        send6(8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5);
        chk("sync_as_data_ok", 32'(frame_ok), 32'd1);
        idle(10);

        // Timeout after A5 01, then a normal frame is accepted.
        e0 = err_pulses;
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(2100);
        chk("timeout_err_pulses", 32'(err_pulses - e0), 32'd1);
        send6(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00);
        chk("post_timeout_ok", 32'(frame_ok), 32'd1);
        wait_idle(200);

        // Channel 6 is rejected.
        h0 = hi_cycles;
        send6(8'hA5, 8'h06, 8'h00, 8'h00, 8'h01, 8'h07);
        chk("ch6_err", 32'(frame_err), 32'd1);
        idle(60);
        chk("ch6_no_strobe", 32'(hi_cycles - h0), 32'd0);

        // Asynchronous reset mid-pulse, with fail set beforehand.
        send6(8'hA5, 8'h04, 8'h00, 8'h00, 8'h05, 8'h01);
        send6(8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'hFF);
        wait_strobe(200);
        idle(3);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_strobe", 32'(strobe), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_fail", 32'(fail), 32'd0);
`ifdef PPI_CMD_STAT_EN
        chk("arst_cnts", 32'(ok_cnt | err_cnt | drop_cnt), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        // Randomized frames, possibly overlapping a running pulse.
        for (int n = 0; n < 40; n++) begin
            c = 8'($urandom_range(0, 7));
            c[6:3] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) c[7] = 1'b1;
            hi = 8'h00;
            lo = 8'($urandom_range(0, 8));
            w  = 8'($urandom_range(0, 6));
            cs = c ^ hi ^ lo ^ w;
            if ($urandom_range(0, 9) == 0) cs = ~cs;
            if ($urandom_range(0, 3) == 0) begin
                nz = 8'($urandom_range(0, 255));
                if (nz == 8'hA5) nz = 8'h5A;
                send_byte(nz);
            end
            send_byte(8'hA5); idle($urandom_range(0, 2));
            send_byte(c);     idle($urandom_range(0, 2));
            send_byte(hi);    idle($urandom_range(0, 2));
            send_byte(lo);    idle($urandom_range(0, 2));
            send_byte(w);     idle($urandom_range(0, 2));
            send_byte(cs);
            idle($urandom_range(0, 250));
        end
        wait_idle(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppi_cmd_strobe.md
Name: ppi_cmd_strobe

Overview:
- Consumes the byte stream produced by the PPI receiver stage and decodes 6-byte command frames.
- Schedules one timed strobe pulse on one of five timing lines: TNO, TNC, TOBM, TNI, TKI.
- Delay and pulse width are measured in ticks of the 1 us timebase (t1us_20 from time_1us_2us).
- Sits directly downstream of PPI_recv and drives the TNO/TNC/TOBM/TNI/TKI output buffers.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_US, 16'd100, maximum t1us ticks allowed between bytes of one frame.
- NCH, 5, number of strobe channels; fixed at 5.

Ports:
- clk  in  1  system clock (20 MHz CLKIN_IBUFG domain).
- rst_n  in  1  asynchronous active-low reset.
- t1us  in  1  one-clk-wide 1 us tick.
- rx_data  in  8  byte from PPI receiver.
- rx_valid  in  1  rx_data valid, one clk per byte.
- strobe  out  5  one-hot timing outputs: [0]TNO [1]TNC [2]TOBM [3]TNI [4]TKI.
- busy  out  1  scheduler is not IDLE.
- frame_ok  out  1  one-clk pulse on an accepted frame.
- frame_err  out  1  one-clk pulse on checksum, channel or timeout error.
- busy_err  out  1  one-clk pulse when a valid frame is dropped because the scheduler is busy.
- fail  out  1  sticky error flag; cleared by the next frame_ok.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - Both FSMs go to their initial state.
  - All counters 0.
  - Reset mid-pulse drops strobe immediately.
- Frame format, bytes B0..B5:
  - B0 = SYNC_BYTE.
  - B1 = cmd: [2:0] channel, [7] abort, [6:3] ignored.
  - B2 = delay_hi, B3 = delay_lo (16-bit delay).
  - B4 = width (8-bit).
  - B5 = B1^B2^B3^B4.
- Receiver FSM states: HUNT, COLLECT.
  - HUNT: a byte equal to SYNC_BYTE goes to COLLECT with idx=1; any other byte is ignored.
  - COLLECT: store the byte at idx, idx++.
  - On B5: compare the checksum, then return to HUNT.
  - Inter-byte gap counter counts t1us ticks and is cleared on each rx_valid.
  - Gap counter reaching TIMEOUT_US in COLLECT: frame_err, go to HUNT.
  - A SYNC_BYTE inside COLLECT is treated as data (no resync).
- Frame evaluation, in the cycle after B5:
  - Checksum bad, or channel > 4 with abort=0: frame_err pulse, fail=1.
  - abort=1 with good checksum: scheduler forced to IDLE, strobe=0, frame_ok pulse. Accepted in any scheduler state.
  - Otherwise, scheduler IDLE: load, frame_ok pulse, fail=0.
  - Otherwise, scheduler not IDLE: frame dropped, busy_err pulse; fail unchanged.
- Scheduler FSM states: IDLE, WAIT, PULSE.
  - IDLE, on load: cnt = delay, ch latched, go to WAIT.
  - WAIT, on t1us:
    - cnt==0 and width==0: go to IDLE with no pulse.
    - cnt==0 and width>0: cnt = width, go to PULSE.
    - Otherwise cnt--.
    - Net effect: the pulse starts on tick number delay+1 after load.
  - PULSE: strobe[ch]=1 (registered). On t1us cnt--; at cnt==0 go to IDLE and strobe=0. High for exactly width ticks.
- busy = (state != IDLE).
- Arithmetic:
  - cnt is 16 bit and never wraps; decrement only when cnt > 0.
  - delay 16'hFFFF is legal (about 65.5 ms).
- Simultaneous events:
  - rx_valid and t1us in the same clk: both processed; the gap counter clears, with the clear taking priority.
  - Abort frame evaluation and a t1us tick in the same clk: abort wins.
- Latency:
  - frame_ok is 1 clk after the B5 rx_valid.
  - strobe rises 1 clk after the qualifying t1us.

Optional Feature:
- Macro: PPI_CMD_STAT_EN.
- Defined:
  - Adds outputs ok_cnt[15:0], err_cnt[15:0], drop_cnt[15:0].
  - Counted on frame_ok, frame_err and busy_err respectively.
  - Each saturates at 16'hFFFF and resets to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good frame A5 02 00 03 04 05, t1us every 20 clk:
  - frame_ok 1 clk after B5.
  - strobe[2] rises after the 4th tick and stays high 4 ticks (80 clk).
  - busy high throughout; fail=0.
- Bad checksum A5 01 00 00 02 FF -> frame_err pulse, fail=1, strobe stays 0.
- Recovery: then A5 00 00 00 01 01 -> fail cleared, strobe[0] high 1 tick after the 1st tick.
- Second frame during WAIT of delay 16'h0100 -> busy_err pulse; the original pulse timing is unchanged.
- Abort during PULSE:
  - Stimulus: A5 80 00 00 00 80 while strobe[3] is high.
  - Response: strobe=0 and busy=0 within 2 clk; frame_ok pulse.
- Timeout: A5 01, then no bytes for 100 ticks -> frame_err, FSM back in HUNT.
  - Follow-up A5 01 00 00 01 00 is accepted.
- Reset: assert rst_n=0 mid-PULSE -> strobe=0 asynchronously, all counters 0.
- Channel 6 frame A5 06 00 00 01 07 -> frame_err, no strobe.
